ultrasonic_ranger_ctrl: RTL

ULTRASONIC_RANGER_CTRL -- requirements
Module: ultrasonic_ranger_ctrl

---
 rtl/ultrasonic_ranger_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger_ctrl.sv
// ultrasonic_ranger_ctrl
// Sequences an ultrasonic ranging sensor: it issues a trigger pulse, waits
// for the echo to rise, times the echo width and then holds off before the
// next measurement. Measurements repeat for as long as enable is high.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   run continuous measurement cycles
//   echo         in   sensor echo, asynchronous to clk
//   trigger      out  sensor trigger pulse, registered
//   echo_cycles  out  last measured echo width in clk cycles, held
//   meas_valid   out  one-cycle pulse when a new result is published
//   meas_timeout out  qualifies meas_valid: echo never came or saturated
//   obstacle     out  held: last published echo_cycles < NEAR_THRESH
//   busy         out  high whenever the controller is not idle
module ultrasonic_ranger_ctrl #(
   parameter int unsigned TRIG_CYCLES    = 1000,
   parameter int unsigned ECHO_WAIT_MAX  = 100000,
   parameter int unsigned ECHO_MAX       = 4000000,
   parameter int unsigned HOLDOFF_CYCLES = 6000000,
   parameter int unsigned NEAR_THRESH    = 58000,
   parameter int unsigned CNT_W          = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             echo,
   output logic             trigger,
   output logic [CNT_W-1:0] echo_cycles,
   output logic             meas_valid,
   output logic             meas_timeout,
   output logic             obstacle,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_ECHO = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   // Terminal counts: each phase ends in the cycle its counter shows LAST.
   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] ECHO_SAT  = CNT_W'(ECHO_MAX);
   localparam logic [CNT_W-1:0] NEAR_TH   = CNT_W'(NEAR_THRESH);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;

   logic             echo_m;
   logic             echo_s;
   logic             echo_d;
   logic             echo_rise;

   logic             trigger_nx;
   logic [CNT_W-1:0] echo_cycles_nx;
   logic             meas_valid_nx;
   logic             meas_timeout_nx;
   logic             obstacle_nx;
   logic             busy_nx;

   // Two-flop synchroniser plus a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   // A level already high on WAIT_ECHO entry never produces a rise, so a
   // stale echo must fall and rise again before it is timed.
   assign echo_rise = echo_s & ~echo_d;

   // Next-state and next-output logic.
   always_comb begin
      state_nx        = state;
      cnt_nx          = cnt;
      trigger_nx      = 1'b0;
      echo_cycles_nx  = echo_cycles;
      meas_valid_nx   = 1'b0;
      meas_timeout_nx = 1'b0;
      obstacle_nx     = obstacle;

      case (state)
         IDLE: begin
            if (enable) begin
               state_nx   = TRIG;
               cnt_nx     = CNT_ZERO;
               trigger_nx = 1'b1;
            end
         end

         TRIG: begin
            if (cnt == TRIG_LAST) begin
               state_nx = WAIT_ECHO;
               cnt_nx   = CNT_ZERO;
            end else begin
               cnt_nx     = cnt + CNT_ONE;
               trigger_nx = 1'b1;
            end
         end

         WAIT_ECHO: begin
            // The rise cycle is the first high cycle, so it counts as one.
            if (echo_rise) begin
               state_nx = MEASURE;
               cnt_nx   = CNT_ONE;
            end else if (cnt == WAIT_LAST) begin
               state_nx        = HOLDOFF;
               cnt_nx          = CNT_ZERO;
               echo_cycles_nx  = ECHO_SAT;
               meas_valid_nx   = 1'b1;
               meas_timeout_nx = 1'b1;
               obstacle_nx     = 1'b0;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end

         MEASURE: begin
            if (!echo_s) begin
               state_nx       = HOLDOFF;
               cnt_nx         = CNT_ZERO;
               echo_cycles_nx = cnt;
               meas_valid_nx  = 1'b1;
               obstacle_nx    = (cnt < NEAR_TH);
            end else if (cnt == ECHO_LAST) begin
               // This high cycle is the ECHO_MAX-th: publish saturation now.
               state_nx        = HOLDOFF;
               cnt_nx          = CNT_ZERO;
               echo_cycles_nx  = ECHO_SAT;
               meas_valid_nx   = 1'b1;
               meas_timeout_nx = 1'b1;
               obstacle_nx     = 1'b0;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end

         HOLDOFF: begin
            if (cnt == HOLD_LAST) begin
               cnt_nx = CNT_ZERO;
               if (enable) begin
                  state_nx   = TRIG;
                  trigger_nx = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end

         default: begin
            state_nx = IDLE;
            cnt_nx   = CNT_ZERO;
         end
      endcase

      busy_nx = (state_nx != IDLE);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= CNT_ZERO;
         trigger      <= 1'b0;
         echo_cycles  <= CNT_ZERO;
         meas_valid   <= 1'b0;
         meas_timeout <= 1'b0;
         obstacle     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         trigger      <= trigger_nx;
         echo_cycles  <= echo_cycles_nx;
         meas_valid   <= meas_valid_nx;
         meas_timeout <= meas_timeout_nx;
         obstacle     <= obstacle_nx;
         busy         <= busy_nx;
      end
   end

endmodule
